msx_bus_arbiter: RTL and testbench

- Shares one internal bus target (VDP/register/memory side) between two masters: M0 = MSX slot bridge (timing-critical host path), M1 = internal master (initializer/DMA/debug).
- Both sides use the internal handshake set: memreq, ioreq, address, write, valid/ready, wdata, and rdata/rdata_en.
- Round-robin grant with single-transaction ownership.
- Tracks outstanding reads and routes the returned read data only to the owning master.
- Returns open-bus data (FFh) if the target never answers.

---
 rtl/msx_bus_pkg.sv | 16 +
 rtl/msx_rr_arb2.sv | 20 ++
 rtl/msx_bus_arbiter.sv | 165 ++++++++++++++++
 tb/tb_msx_bus_arbiter.sv | 357 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/msx_bus_pkg.sv
// Shared types and bus widths for the MSX internal-bus arbiter.
package msx_bus_pkg;

  localparam int ADDR_W = 16;
  localparam int DATA_W = 8;

  // Value seen on a floating MSX data bus; returned when the target never answers a read.
  localparam logic [DATA_W-1:0] OPEN_BUS_DATA = 8'hFF;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT   = 2'd1,
    WAIT_RD = 2'd2
  } arb_state_e;

endpackage

// File: rtl/msx_rr_arb2.sv
// Two-way round-robin selector: a lone requester wins, a tie goes to the master not served last.
module msx_rr_arb2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic       gnt_vld,
  output logic       gnt_idx
);

  always_comb begin
    gnt_vld = |req;
    gnt_idx = 1'b0;
    case (req)
      2'b01:   gnt_idx = 1'b0;
      2'b10:   gnt_idx = 1'b1;
      2'b11:   gnt_idx = ~last;
      default: gnt_idx = 1'b0;
    endcase
  end

endmodule

// File: rtl/msx_bus_arbiter.sv
// Shares one internal bus target between the MSX slot bridge (M0) and an internal master (M1),
// one transaction at a time, routing read data back only to the owning master.
module msx_bus_arbiter
  import msx_bus_pkg::*;
#(
  parameter int RD_TIMEOUT = 64,
  parameter int TO_W       = 7
) (
  input  logic              clk42m,
  input  logic              reset,
  input  logic              m0_memreq,
  input  logic              m0_ioreq,
  input  logic [ADDR_W-1:0] m0_address,
  input  logic              m0_write,
  input  logic              m0_valid,
  output logic              m0_ready,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic [DATA_W-1:0] m0_rdata,
  output logic              m0_rdata_en,
  input  logic              m1_memreq,
  input  logic              m1_ioreq,
  input  logic [ADDR_W-1:0] m1_address,
  input  logic              m1_write,
  input  logic              m1_valid,
  output logic              m1_ready,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              m1_rdata_en,
  output logic              s_memreq,
  output logic              s_ioreq,
  output logic [ADDR_W-1:0] s_address,
  output logic              s_write,
  output logic              s_valid,
  input  logic              s_ready,
  output logic [DATA_W-1:0] s_wdata,
  input  logic [DATA_W-1:0] s_rdata,
  input  logic              s_rdata_en
);

  localparam logic [TO_W-1:0] TO_LAST = TO_W'(RD_TIMEOUT - 1);

  arb_state_e        state_q, state_d;
  logic              owner_q, owner_d;
  logic              last_q, last_d;
  logic [TO_W-1:0]   to_cnt_q, to_cnt_d;
  logic              gnt_vld, gnt_idx;
  logic              acc;
  logic              own_memreq, own_ioreq, own_write, own_valid;
  logic [ADDR_W-1:0] own_address;
  logic [DATA_W-1:0] own_wdata;
  logic              rsp_vld_p0;
  logic [DATA_W-1:0] rsp_data_p0;

  msx_rr_arb2 u_rr (
    .req     ({m1_valid, m0_valid}),
    .last    (last_q),
    .gnt_vld (gnt_vld),
    .gnt_idx (gnt_idx)
  );

  always_comb begin
    own_memreq  = owner_q ? m1_memreq  : m0_memreq;
    own_ioreq   = owner_q ? m1_ioreq   : m0_ioreq;
    own_address = owner_q ? m1_address : m0_address;
    own_write   = owner_q ? m1_write   : m0_write;
    own_valid   = owner_q ? m1_valid   : m0_valid;
    own_wdata   = owner_q ? m1_wdata   : m0_wdata;
  end

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    last_d      = last_q;
    to_cnt_d    = to_cnt_q;
    acc         = 1'b0;
    rsp_vld_p0  = 1'b0;
    rsp_data_p0 = OPEN_BUS_DATA;
    s_memreq    = 1'b0;
    s_ioreq     = 1'b0;
    s_address   = '0;
    s_write     = 1'b0;
    s_valid     = 1'b0;
    s_wdata     = '0;
    case (state_q)
      IDLE: begin
        if (gnt_vld) begin
          owner_d = gnt_idx;
          last_d  = gnt_idx;
          state_d = GRANT;
        end
      end
      GRANT: begin
        // An owner withdrawing its request abandons the grant without a ready pulse.
        if (own_valid) begin
          s_memreq  = own_memreq;
          s_ioreq   = own_ioreq;
          s_address = own_address;
          s_write   = own_write;
          s_wdata   = own_wdata;
          s_valid   = 1'b1;
          if (s_ready) begin
            acc = 1'b1;
            if (own_write) begin
              state_d = IDLE;
            end else if (s_rdata_en) begin
              rsp_vld_p0  = 1'b1;
              rsp_data_p0 = s_rdata;
              state_d     = IDLE;
            end else begin
              to_cnt_d = '0;
              state_d  = WAIT_RD;
            end
          end
        end else begin
          state_d = IDLE;
        end
      end
      WAIT_RD: begin
        if (s_rdata_en) begin
          rsp_vld_p0  = 1'b1;
          rsp_data_p0 = s_rdata;
          state_d     = IDLE;
        end else if (to_cnt_q == TO_LAST) begin
          rsp_vld_p0 = 1'b1;
          state_d    = IDLE;
        end else begin
          to_cnt_d = to_cnt_q + TO_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
    m0_ready = acc & ~owner_q;
    m1_ready = acc & owner_q;
  end

  always_ff @(posedge clk42m or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      owner_q  <= 1'b0;
      last_q   <= 1'b1;
      to_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      last_q   <= last_d;
      to_cnt_q <= to_cnt_d;
    end
  end

  // p0 -> p1: read response registered toward the owning master only.
  always_ff @(posedge clk42m or posedge reset) begin
    if (reset) begin
      m0_rdata    <= '0;
      m0_rdata_en <= 1'b0;
      m1_rdata    <= '0;
      m1_rdata_en <= 1'b0;
    end else begin
      m0_rdata_en <= rsp_vld_p0 & ~owner_q;
      m1_rdata_en <= rsp_vld_p0 & owner_q;
      if (rsp_vld_p0 && !owner_q) m0_rdata <= rsp_data_p0;
      if (rsp_vld_p0 && owner_q)  m1_rdata <= rsp_data_p0;
    end
  end

endmodule

// File: tb/tb_msx_bus_arbiter.sv
// Scoreboard bench for msx_bus_arbiter: randomized masters and target against a transaction-level model.
module tb_msx_bus_arbiter;

  typedef struct {
    logic        memreq;
    logic        ioreq;
    logic [15:0] addr;
    logic        write;
    logic [7:0]  wdata;
  } req_t;

  typedef struct {
    logic [7:0] data;
    int         cyc;
  } rsp_t;

  logic        clk42m = 1'b0;
  logic        reset  = 1'b1;
  logic        m0_memreq = 0, m0_ioreq = 0, m0_write = 0, m0_valid = 0;
  logic [15:0] m0_address = '0;
  logic [7:0]  m0_wdata = '0;
  logic        m1_memreq = 0, m1_ioreq = 0, m1_write = 0, m1_valid = 0;
  logic [15:0] m1_address = '0;
  logic [7:0]  m1_wdata = '0;
  logic        m0_ready, m0_rdata_en, m1_ready, m1_rdata_en;
  logic [7:0]  m0_rdata, m1_rdata;
  logic        s_memreq, s_ioreq, s_write, s_valid;
  logic [15:0] s_address;
  logic [7:0]  s_wdata;
  logic        s_ready = 0, s_rdata_en = 0;
  logic [7:0]  s_rdata = '0;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  req_t exp_req0[$];
  req_t exp_req1[$];
  rsp_t rd_exp[$];
  int   rd_owner[$];
  logic [7:0] last_rd [2];

  // Target behaviour knobs: -1 means randomize.
  int fix_lat   = -1;
  int fix_rlat  = -1;
  int fix_data  = -1;
  int rmode     = 3;   // 0 normal, 1 zero-latency, 2 never answers, 3 random mix
  bit tgt_hold  = 0;
  bit tie_mode  = 0;
  int alt_exp   = 0;

  msx_bus_arbiter #(.RD_TIMEOUT(64), .TO_W(7)) dut (
    .clk42m      (clk42m),
    .reset       (reset),
    .m0_memreq   (m0_memreq),
    .m0_ioreq    (m0_ioreq),
    .m0_address  (m0_address),
    .m0_write    (m0_write),
    .m0_valid    (m0_valid),
    .m0_ready    (m0_ready),
    .m0_wdata    (m0_wdata),
    .m0_rdata    (m0_rdata),
    .m0_rdata_en (m0_rdata_en),
    .m1_memreq   (m1_memreq),
    .m1_ioreq    (m1_ioreq),
    .m1_address  (m1_address),
    .m1_write    (m1_write),
    .m1_valid    (m1_valid),
    .m1_ready    (m1_ready),
    .m1_wdata    (m1_wdata),
    .m1_rdata    (m1_rdata),
    .m1_rdata_en (m1_rdata_en),
    .s_memreq    (s_memreq),
    .s_ioreq     (s_ioreq),
    .s_address   (s_address),
    .s_write     (s_write),
    .s_valid     (s_valid),
    .s_ready     (s_ready),
    .s_wdata     (s_wdata),
    .s_rdata     (s_rdata),
    .s_rdata_en  (s_rdata_en)
  );

  always #12 clk42m = ~clk42m;
  always @(posedge clk42m) cyc <= cyc + 1;

  function automatic void chk(string nm, longint act, longint expv);
    tests++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, expv, cyc);
    end
  endfunction

  function automatic void clear_model();
    exp_req0.delete();
    exp_req1.delete();
    rd_exp.delete();
    rd_owner.delete();
    last_rd[0] = 8'h00;
    last_rd[1] = 8'h00;
  endfunction

  // Issue one request from master m and hold it until accepted.
  task automatic drive(int m, logic io, logic [15:0] a, logic w, logic [7:0] d);
    req_t r;
    int n;
    r.memreq = ~io; r.ioreq = io; r.addr = a; r.write = w; r.wdata = d;
    if (m == 0) begin
      exp_req0.push_back(r);
      m0_memreq = ~io; m0_ioreq = io; m0_address = a; m0_write = w; m0_wdata = d; m0_valid = 1'b1;
    end else begin
      exp_req1.push_back(r);
      m1_memreq = ~io; m1_ioreq = io; m1_address = a; m1_write = w; m1_wdata = d; m1_valid = 1'b1;
    end
    n = 0;
    do begin
      @(negedge clk42m);
      n++;
    end while (!(m == 0 ? m0_ready : m1_ready) && n < 400);
    if (n >= 400) chk($sformatf("m%0d_accept_timeout", m), 0, 1);
    @(posedge clk42m);
    #1;
    if (m == 0) m0_valid = 1'b0; else m1_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_req0.size() + exp_req1.size() + rd_exp.size() + rd_owner.size()) != 0 && n < 400) begin
      @(negedge clk42m);
      n++;
    end
    chk("drain_outstanding", exp_req0.size() + exp_req1.size() + rd_exp.size() + rd_owner.size(), 0);
    repeat (3) @(posedge clk42m);
    #1;
  endtask

  // Target model: accepts after a delay, then answers reads per the chosen mode.
  initial begin : target
    int lat, rlat, mode, d;
    bit rd;
    forever begin
      @(negedge clk42m);
      if (s_valid && !reset && !tgt_hold) begin
        lat = (fix_lat >= 0) ? fix_lat : int'($urandom_range(1, 4));
        repeat (lat) @(posedge clk42m);
        #1;
        if (s_valid && !tgt_hold) begin
          if (rmode == 3) begin
            mode = int'($urandom_range(0, 19));
            mode = (mode == 0) ? 1 : (mode == 1) ? 2 : 0;
          end else begin
            mode = rmode;
          end
          d    = (fix_data >= 0) ? fix_data : int'($urandom_range(0, 255));
          rlat = (fix_rlat >= 0) ? fix_rlat : int'($urandom_range(0, 15));
          rd   = ~s_write;
          s_ready = 1'b1;
          if (rd && mode == 1) begin
            s_rdata = 8'(d); s_rdata_en = 1'b1;
            rd_exp.push_back('{data: 8'(d), cyc: cyc + 1});
          end else if (rd && mode == 2) begin
            rd_exp.push_back('{data: 8'hFF, cyc: cyc + 1 + 64});
          end
          @(posedge clk42m);
          #1;
          s_ready = 1'b0; s_rdata_en = 1'b0;
          if (rd && mode == 0) begin
            for (int i = 0; i < rlat; i++) begin
              @(posedge clk42m);
              #1;
            end
            s_rdata = 8'(d); s_rdata_en = 1'b1;
            rd_exp.push_back('{data: 8'(d), cyc: cyc + 1});
            @(posedge clk42m);
            #1;
            s_rdata_en = 1'b0;
          end
        end
      end
    end
  end

  // Monitor: request handshakes and read-data strobes against the scoreboard queues.
  always @(negedge clk42m) begin
    req_t r;
    rsp_t e;
    int m, o;
    if (!reset) begin
      if (s_valid && s_ready) begin
        chk("ready_onehot", m0_ready + m1_ready, 1);
        m = m1_ready ? 1 : 0;
        if (tie_mode) begin
          chk("grant_order", m, alt_exp);
          alt_exp = 1 - alt_exp;
        end
        if ((m == 0 ? exp_req0.size() : exp_req1.size()) == 0) begin
          chk($sformatf("m%0d_unexpected_grant", m), 1, 0);
        end else begin
          r = (m == 0) ? exp_req0.pop_front() : exp_req1.pop_front();
          chk($sformatf("m%0d_s_address", m), s_address, r.addr);
          chk($sformatf("m%0d_s_write", m), s_write, r.write);
          chk($sformatf("m%0d_s_memreq", m), s_memreq, r.memreq);
          chk($sformatf("m%0d_s_ioreq", m), s_ioreq, r.ioreq);
          chk($sformatf("m%0d_s_wdata", m), s_wdata, r.wdata);
          if (!r.write) rd_owner.push_back(m);
        end
      end else if (m0_ready || m1_ready) begin
        chk("ready_without_handshake", 1, 0);
      end
      if (m0_rdata_en || m1_rdata_en) begin
        if (m0_rdata_en && m1_rdata_en) begin
          chk("rdata_en_both", 1, 0);
        end else if (rd_exp.size() == 0 || rd_owner.size() == 0) begin
          chk("rdata_en_spurious", 1, 0);
        end else begin
          e = rd_exp.pop_front();
          o = rd_owner.pop_front();
          chk("rd_owner", m1_rdata_en ? 1 : 0, o);
          chk("rd_data", o == 1 ? m1_rdata : m0_rdata, e.data);
          chk("rd_cycle", cyc, e.cyc);
          chk("rd_other_hold", o == 1 ? m0_rdata : m1_rdata, last_rd[1 - o]);
          last_rd[o] = e.data;
        end
      end
    end
  end

  initial begin : watchdog
    #(24 * 60000);
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
    $fatal(1, "watchdog");
  end

  initial begin : main
    clear_model();
    repeat (3) @(negedge clk42m);
    chk("rst_s_valid", s_valid, 0);
    chk("rst_m0_ready", m0_ready, 0);
    chk("rst_m1_ready", m1_ready, 0);
    chk("rst_rdata_en", {m1_rdata_en, m0_rdata_en}, 0);
    chk("rst_rdata", {m1_rdata, m0_rdata}, 0);
    reset = 1'b0;
    @(posedge clk42m);
    #1;

    // M0 I/O write 98h <- 12h, target accepts after 3 cycles.
    fix_lat = 3; rmode = 0;
    drive(0, 1'b1, 16'h0098, 1'b1, 8'h12);
    drain();

    // M1 memory read 1234h, data 5Ah returned 10 cycles after acceptance.
    fix_lat = 1; fix_rlat = 10; fix_data = 8'h5A;
    drive(1, 1'b0, 16'h1234, 1'b0, 8'h00);
    drain();
    chk("m1_rdata_5a", m1_rdata, 8'h5A);
    chk("m0_rdata_untouched", m0_rdata, 8'h00);

    // Target never answers: open-bus FFh after the timeout, then a new grant.
    rmode = 2;
    drive(1, 1'b1, 16'h00A8, 1'b0, 8'h00);
    rmode = 0; fix_data = -1;
    drive(0, 1'b0, 16'hC000, 1'b1, 8'h77);
    drain();
    chk("m1_rdata_ff", m1_rdata, 8'hFF);

    // Zero-latency target for an M0 read.
    rmode = 1; fix_data = 8'h3C;
    drive(0, 1'b0, 16'h2000, 1'b0, 8'h00);
    drain();
    chk("m0_rdata_3c", m0_rdata, 8'h3C);

    // Owner withdraws its request before ready; then a stray strobe while idle.
    tgt_hold = 1; rmode = 0; fix_data = -1;
    m1_memreq = 1; m1_ioreq = 0; m1_address = 16'h5555; m1_write = 1; m1_wdata = 8'hAA; m1_valid = 1;
    repeat (3) @(negedge clk42m);
    chk("pv_s_valid_up", s_valid, 1);
    @(posedge clk42m);
    #1;
    m1_valid = 0;
    #1;
    chk("pv_s_valid_drop", s_valid, 0);
    chk("pv_m1_ready", m1_ready, 0);
    @(negedge clk42m);
    chk("pv_idle_s_valid", s_valid, 0);
    tgt_hold = 0;
    @(posedge clk42m);
    #1;
    s_rdata = 8'h99; s_rdata_en = 1'b1;
    @(posedge clk42m);
    #1;
    s_rdata_en = 1'b0;
    drive(0, 1'b1, 16'h0099, 1'b1, 8'h01);
    drain();

    // Randomized traffic from both masters.
    fix_lat = -1; fix_rlat = -1; fix_data = -1; rmode = 3;
    fork
      for (int i = 0; i < 30; i++) begin
        drive(0, 1'($urandom_range(0, 1)), 16'($urandom), 1'($urandom_range(0, 1)), 8'($urandom));
        repeat ($urandom_range(0, 3)) @(posedge clk42m);
        #1;
      end
      for (int j = 0; j < 30; j++) begin
        drive(1, 1'($urandom_range(0, 1)), 16'($urandom), 1'($urandom_range(0, 1)), 8'($urandom));
        repeat ($urandom_range(0, 3)) @(posedge clk42m);
        #1;
      end
    join
    drain();

    // Reset asserted while a read is outstanding in WAIT_RD.
    rmode = 2; fix_lat = 1;
    drive(0, 1'b0, 16'h0100, 1'b0, 8'h00);
    repeat (5) @(posedge clk42m);
    #3;
    clear_model();
    reset = 1'b1;
    #1;
    chk("arst_s_valid", s_valid, 0);
    chk("arst_s_address", s_address, 0);
    chk("arst_ready", {m1_ready, m0_ready}, 0);
    chk("arst_rdata_en", {m1_rdata_en, m0_rdata_en}, 0);
    chk("arst_rdata", {m1_rdata, m0_rdata}, 0);
    repeat (3) @(negedge clk42m);
    reset = 1'b0;
    @(posedge clk42m);
    #1;
    rmode = 0; fix_rlat = 4; fix_data = 8'hA5;
    drive(0, 1'b0, 16'h4567, 1'b0, 8'h00);
    drain();
    chk("m0_rdata_a5", m0_rdata, 8'hA5);

    // Tie right after reset: strict alternation starting with M0.
    reset = 1'b1;
    clear_model();
    repeat (2) @(negedge clk42m);
    reset = 1'b0;
    @(posedge clk42m);
    #1;
    fix_lat = -1; fix_rlat = -1; fix_data = -1; rmode = 0;
    tie_mode = 1; alt_exp = 0;
    fork
      for (int i = 0; i < 4; i++) drive(0, 1'b0, 16'h8000 + 16'(i), 1'(i % 2), 8'(i));
      for (int j = 0; j < 4; j++) drive(1, 1'b1, 16'h0040 + 16'(j), 1'((j + 1) % 2), 8'(j + 16));
    join
    drain();
    tie_mode = 0;
    chk("grant_count", alt_exp, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
